// File: rtl/alu_rs_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_pkg
//   Encodings shared between the ALU reservation station and the ALU itself,
//   so both ends of the operand interface agree on op codes and tag widths.
//   Contents: ALU op code localparams (ADD..GEU, 4 bit), ROB tag width,
//   NULL tag (no instruction), data width.
// -----------------------------------------------------------------------------
package alu_rs_pkg;

   localparam int DATA_W   = 32;
   localparam int OP_W     = 4;
   localparam int RS_TAG_W = 3;

   // Tag 0 never names a real instruction; an idle ALU input carries it.
   localparam logic [RS_TAG_W-1:0] NULL_TAG = '0;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
   localparam logic [OP_W-1:0] ALU_AND  = 4'd9;
   localparam logic [OP_W-1:0] ALU_EQ   = 4'd10;
   localparam logic [OP_W-1:0] ALU_NE   = 4'd11;
   localparam logic [OP_W-1:0] ALU_LT   = 4'd12;
   localparam logic [OP_W-1:0] ALU_GE   = 4'd13;
   localparam logic [OP_W-1:0] ALU_LTU  = 4'd14;
   localparam logic [OP_W-1:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/alu_rs_if.sv
// -----------------------------------------------------------------------------
// alu_rs_if
//   Bus bundle around the ALU reservation station:
//     issue  : in_valid/in_ready handshake plus decoded op and operand state
//     cdb    : cdb_valid/cdb_tag/cdb_value result broadcast
//     alu    : alu_value_1/alu_value_2/alu_op/alu_des registered dispatch
//   master = issue stage / CDB / ALU side, slave = reservation station.
// -----------------------------------------------------------------------------
interface alu_rs_if #(
   parameter int TAG_W = alu_rs_pkg::RS_TAG_W
);
   import alu_rs_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [DATA_W-1:0] in_vj;
   logic [TAG_W-1:0]  in_qj;
   logic              in_qj_busy;
   logic [DATA_W-1:0] in_vk;
   logic [TAG_W-1:0]  in_qk;
   logic              in_qk_busy;
   logic [TAG_W-1:0]  in_dest;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_value;

   logic [DATA_W-1:0] alu_value_1;
   logic [DATA_W-1:0] alu_value_2;
   logic [OP_W-1:0]   alu_op;
   logic [TAG_W-1:0]  alu_des;

   modport master (
      output in_valid, in_op, in_vj, in_qj, in_qj_busy,
             in_vk, in_qk, in_qk_busy, in_dest,
             cdb_valid, cdb_tag, cdb_value,
      input  in_ready, alu_value_1, alu_value_2, alu_op, alu_des
   );

   modport slave (
      input  in_valid, in_op, in_vj, in_qj, in_qj_busy,
             in_vk, in_qk, in_qk_busy, in_dest,
             cdb_valid, cdb_tag, cdb_value,
      output in_ready, alu_value_1, alu_value_2, alu_op, alu_des
   );

endinterface

// File: rtl/alu_rs_pick_lowest.sv
// -----------------------------------------------------------------------------
// rs_pick_lowest
//   Fixed-priority picker: grants the lowest-index set bit of req.
//   Ports: req   in  N  request vector
//          grant out N  one-hot grant (all zero when no request)
//          valid out 1  at least one request present
// -----------------------------------------------------------------------------
module rs_pick_lowest #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         valid
);

   // Bit gi wins only if no lower-index bit is requesting.
   for (genvar gi = 0; gi < N; gi++) begin : g_grant
      localparam logic [N-1:0] LOWER_MASK = (N'(1) << gi) - N'(1);
      assign grant[gi] = req[gi] & ~(|(req & LOWER_MASK));
   end

   assign valid = |req;

endmodule

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
//   Reservation station feeding the ALU. Holds decoded ALU ops until both
//   operands are valid, snoops the CDB for pending operands and dispatches
//   the lowest-index ready entry each cycle as registered alu_* outputs.
//   Ports: clk        system clock, all state on posedge
//          rst_n      asynchronous active-low reset
//          flush      synchronous clear of all entries (wins over issue/CDB)
//          bus        alu_rs_if.slave: issue handshake, CDB snoop, ALU outputs
//          occupancy  number of busy entries
// -----------------------------------------------------------------------------
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = RS_TAG_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_rs_if.slave    bus,
   output logic [3:0] occupancy
);

   typedef struct packed {
      logic              busy;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [TAG_W-1:0]  qj;
      logic              j_rdy;
      logic [DATA_W-1:0] vk;
      logic [TAG_W-1:0]  qk;
      logic              k_rdy;
      logic [TAG_W-1:0]  dest;
   } entry_t;

   entry_t            entry_reg  [DEPTH];
   entry_t            entry_next [DEPTH];
   entry_t            issue_entry;

   logic [DEPTH-1:0]  free_req;
   logic [DEPTH-1:0]  ready_req;
   logic [DEPTH-1:0]  alloc_grant;
   logic [DEPTH-1:0]  disp_grant;
   logic              alloc_valid;
   logic              disp_valid;
   logic              issue_accept;
   logic              j_bypass;
   logic              k_bypass;
   logic [3:0]        occ_count;

   logic [DATA_W-1:0] sel_vj;
   logic [DATA_W-1:0] sel_vk;
   logic [OP_W-1:0]   sel_op;
   logic [TAG_W-1:0]  sel_dest;

   logic [DATA_W-1:0] alu_value_1_reg;
   logic [DATA_W-1:0] alu_value_2_reg;
   logic [OP_W-1:0]   alu_op_reg;
   logic [TAG_W-1:0]  alu_des_reg;

   // Request vectors come from registered state only, so an entry written
   // or woken this cycle cannot be selected before the next edge.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_req
      assign free_req[gi]  = ~entry_reg[gi].busy;
      assign ready_req[gi] = entry_reg[gi].busy & entry_reg[gi].j_rdy & entry_reg[gi].k_rdy;
   end

   rs_pick_lowest #(.N(DEPTH)) u_pick_free (
      .req   (free_req),
      .grant (alloc_grant),
      .valid (alloc_valid)
   );

   rs_pick_lowest #(.N(DEPTH)) u_pick_ready (
      .req   (ready_req),
      .grant (disp_grant),
      .valid (disp_valid)
   );

   always_comb begin
      occ_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_count = occ_count + {3'b000, entry_reg[i].busy};
      end
   end

   assign occupancy    = occ_count;
   // A slot freed by this cycle's dispatch is deliberately not reusable
   // until the next cycle: readiness looks at registered occupancy only.
   assign bus.in_ready = (occ_count < 4'(DEPTH));
   assign issue_accept = bus.in_valid && bus.in_ready && alloc_valid &&
                         (bus.in_dest != TAG_W'(NULL_TAG)) && !flush;

   // An operand whose producer broadcasts in the issue cycle is captured
   // directly, otherwise it would miss the broadcast and wait forever.
   assign j_bypass = bus.in_qj_busy && bus.cdb_valid && (bus.cdb_tag == bus.in_qj);
   assign k_bypass = bus.in_qk_busy && bus.cdb_valid && (bus.cdb_tag == bus.in_qk);

   always_comb begin
      issue_entry       = '0;
      issue_entry.busy  = 1'b1;
      issue_entry.op    = bus.in_op;
      issue_entry.dest  = bus.in_dest;
      issue_entry.qj    = bus.in_qj;
      issue_entry.qk    = bus.in_qk;
      issue_entry.vj    = j_bypass ? bus.cdb_value : bus.in_vj;
      issue_entry.vk    = k_bypass ? bus.cdb_value : bus.in_vk;
      issue_entry.j_rdy = !bus.in_qj_busy || j_bypass;
      issue_entry.k_rdy = !bus.in_qk_busy || k_bypass;
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t nxt;
      always_comb begin
         nxt = entry_reg[gi];
         if (flush) begin
            nxt.busy = 1'b0;
         end else if (issue_accept && alloc_grant[gi]) begin
            nxt = issue_entry;
         end else begin
            if (disp_grant[gi]) begin
               nxt.busy = 1'b0;
            end
            if (entry_reg[gi].busy && bus.cdb_valid) begin
               if (!entry_reg[gi].j_rdy && (entry_reg[gi].qj == bus.cdb_tag)) begin
                  nxt.vj    = bus.cdb_value;
                  nxt.j_rdy = 1'b1;
               end
               if (!entry_reg[gi].k_rdy && (entry_reg[gi].qk == bus.cdb_tag)) begin
                  nxt.vk    = bus.cdb_value;
                  nxt.k_rdy = 1'b1;
               end
            end
         end
      end
      assign entry_next[gi] = nxt;
   end

   // One-hot grant, so OR-ing the masked fields is a plain mux.
   always_comb begin
      sel_vj   = '0;
      sel_vk   = '0;
      sel_op   = '0;
      sel_dest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_grant[i]) begin
            sel_vj   = sel_vj   | entry_reg[i].vj;
            sel_vk   = sel_vk   | entry_reg[i].vk;
            sel_op   = sel_op   | entry_reg[i].op;
            sel_dest = sel_dest | entry_reg[i].dest;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_reg[i] <= entry_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_value_1_reg <= '0;
         alu_value_2_reg <= '0;
         alu_op_reg      <= '0;
         alu_des_reg     <= TAG_W'(NULL_TAG);
      end else if (flush || !disp_valid) begin
         alu_value_1_reg <= '0;
         alu_value_2_reg <= '0;
         alu_op_reg      <= '0;
         alu_des_reg     <= TAG_W'(NULL_TAG);
      end else begin
         alu_value_1_reg <= sel_vj;
         alu_value_2_reg <= sel_vk;
         alu_op_reg      <= sel_op;
         alu_des_reg     <= sel_dest;
      end
   end

   assign bus.alu_value_1 = alu_value_1_reg;
   assign bus.alu_value_2 = alu_value_2_reg;
   assign bus.alu_op      = alu_op_reg;
   assign bus.alu_des     = alu_des_reg;

endmodule
